// File: rtl/stream_mux_4x1_pkg.sv
// Constants and types shared by the 4-channel stream mux and its companion demux_1x4.
package stream_mux_4x1_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam logic [SEL_W-1:0] RST_LAST_GRANT = 2'd3;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_t;
endpackage

// File: rtl/stream_mux_4x1_if.sv
// Four valid/ready input channels plus one registered output stream with source select.
interface stream_mux_4x1_if #(parameter int WIDTH = 8);
  import stream_mux_4x1_pkg::*;

  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0][WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_ready;
  logic                         out_valid;
  logic [WIDTH-1:0]             out_data;
  logic [SEL_W-1:0]             out_sel;
  logic                         out_ready;

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sel);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/stream_mux_4x1_rr_arbiter_4.sv
// Combinational round-robin pick: searches last+1 .. last+4 (mod 4), first requester wins.
module rr_arbiter_4
  import stream_mux_4x1_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt_onehot,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any_gnt
);
  logic [SEL_W-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    // 2-bit add wraps naturally, so last itself is visited on the final step
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = last + SEL_W'(k);
      if (en && !any_gnt && req[cand]) begin
        gnt_idx = cand;
        any_gnt = 1'b1;
      end
    end
    gnt_onehot = any_gnt ? (NUM_CH'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/stream_mux_4x1.sv
// Round-robin 4:1 stream mux with a one-entry registered output stage.
module stream_mux_4x1
  import stream_mux_4x1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  stream_mux_4x1_if.slave bus
);
  ostate_t          state, state_nxt;
  logic [SEL_W-1:0] last_grant, gnt_idx, sel_q;
  logic [NUM_CH-1:0] gnt_onehot;
  logic             any_gnt, load;
  logic [WIDTH-1:0] data_q;

  assign load = (state == EMPTY) | bus.out_ready;

  // Gating with ~rst keeps in_ready low for the whole reset window
  rr_arbiter_4 u_arb (
    .req        (bus.in_valid),
    .last       (last_grant),
    .en         (load & ~rst),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_gnt    (any_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) state_nxt = any_gnt ? FULL : EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      sel_q      <= '0;
      last_grant <= RST_LAST_GRANT;
    end else if (load && any_gnt) begin
      data_q     <= bus.in_data[gnt_idx];
      sel_q      <= gnt_idx;
      last_grant <= gnt_idx;
    end
  end

  always_comb begin
    bus.out_valid = (state == FULL);
    bus.out_data  = data_q;
    bus.out_sel   = sel_q;
    bus.in_ready  = gnt_onehot;
  end
endmodule

// File: tb/tb_stream_mux_4x1.sv
// Directed + random bench for stream_mux_4x1 with a (channel, data) scoreboard.
module tb_stream_mux_4x1;
  import stream_mux_4x1_pkg::*;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    n_chk = 0, n_fail = 0;
  beat_t sb[$];
  logic [SEL_W-1:0] m_last = RST_LAST_GRANT;
  logic  m_full = 1'b0;

  stream_mux_4x1_if #(.WIDTH(WIDTH)) bus();
  stream_mux_4x1 #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: evaluated mid-cycle with inputs stable, state advanced for the coming edge
  always @(negedge clk) begin
    logic [NUM_CH-1:0] exp_rdy;
    logic [SEL_W-1:0]  g;
    logic              hit, ld;
    beat_t             b;
    chk("onehot0", 32'($onehot0(bus.in_ready)), 1);
    chk("out_valid", bus.out_valid, m_full);
    if (m_full) begin
      if (sb.size() == 0) chk("sb_underflow", 0, 1);
      else begin
        chk("sb_sel", bus.out_sel, sb[0].sel);
        chk("sb_data", bus.out_data, sb[0].data);
      end
    end
    ld  = !m_full || bus.out_ready;
    hit = 1'b0;
    g   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (int'(m_last) + k) % NUM_CH;
      if (!hit && bus.in_valid[idx]) begin
        hit = 1'b1;
        g   = SEL_W'(idx);
      end
    end
    exp_rdy = (!rst && ld && hit) ? (NUM_CH'(1) << g) : '0;
    chk("in_ready", bus.in_ready, exp_rdy);
    if (rst) begin
      m_full = 1'b0;
      m_last = RST_LAST_GRANT;
      sb.delete();
    end else begin
      if (m_full && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      if (ld) begin
        if (hit) begin
          b.sel  = g;
          b.data = bus.in_data[g];
          sb.push_back(b);
          m_full = 1'b1;
          m_last = g;
        end else m_full = 1'b0;
      end
    end
  end

  initial begin
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) bus.in_data[i] = WIDTH'(8'h10 + i);

    // reset with all channels requesting
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 4'b0000);
      chk("rst_out_valid", bus.out_valid, 0);
    end
    cyc(); rst = 1'b0; bus.in_valid = 4'b0000;
    @(negedge clk);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sel", bus.out_sel, 0);

    // single source on ch2
    cyc(); bus.in_valid = 4'b0100; bus.in_data[2] = 8'hA5;
    @(negedge clk);
    chk("single_rdy", bus.in_ready, 4'b0100);
    cyc(); bus.in_valid = 4'b0000;
    @(negedge clk);
    chk("single_valid", bus.out_valid, 1);
    chk("single_data", bus.out_data, 8'hA5);
    chk("single_sel", bus.out_sel, 2);

    // full contention right after reset
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) bus.in_data[i] = WIDTH'(8'h10 + i);
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k == 5) bus.out_ready = 1'b0;
      @(negedge clk);
      chk("rr_sel", bus.out_sel, k % 4);
      chk("rr_data", bus.out_data, 8'h10 + (k % 4));
    end

    // backpressure while holding the ch1 beat
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin cyc(); @(negedge clk); end
      chk("bp_rdy", bus.in_ready, 4'b0000);
      chk("bp_sel", bus.out_sel, 1);
      chk("bp_data", bus.out_data, 8'h11);
    end
    cyc(); bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", bus.in_ready, 4'b0100);
    cyc();
    @(negedge clk);
    chk("bp_next_valid", bus.out_valid, 1);
    chk("bp_next_sel", bus.out_sel, 2);

    // wrap/skip: make last_grant=1, then only ch1 and ch3 request
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; bus.in_valid = 4'b0010;
    cyc(); bus.in_valid = 4'b1010;
    @(negedge clk); chk("wrap_rdy0", bus.in_ready, 4'b1000);
    cyc(); @(negedge clk); chk("wrap_rdy1", bus.in_ready, 4'b0010);
    cyc(); @(negedge clk); chk("wrap_rdy2", bus.in_ready, 4'b1000);

    // reset while FULL and stalled
    cyc(); bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
    cyc(); rst = 1'b1;
    @(negedge clk); chk("mid_rst_rdy", bus.in_ready, 4'b0000);
    cyc(); rst = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_rdy0", bus.in_ready, 4'b0001);
    cyc(); @(negedge clk); chk("mid_rst_sel", bus.out_sel, 0);

    // random traffic, the negedge model checks every cycle
    for (int n = 0; n < 400; n++) begin
      cyc();
      rst           = ($urandom_range(0, 79) == 0);
      bus.in_valid  = NUM_CH'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_CH; i++) bus.in_data[i] = WIDTH'($urandom);
    end

    cyc(); rst = 1'b0; bus.in_valid = '0; bus.out_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    chk("drain_valid", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
